// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: single-master MMIO fabric decoding one strobe to one of NUM_SLAVES ports,
// with ACK timeout, error response and a sticky overrun flag.
module mmio_bus_fabric #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {NUM_SLAVES{32'hF000_0000}},
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_W-1:0]            ADDR,
  input  logic [DATA_W-1:0]            DATA_I,
  input  logic                         WRSTB,
  input  logic                         RDSTB,
  output logic [DATA_W-1:0]            DATA_O,
  output logic                         READY,
  output logic                         ERR,
  output logic                         OVERRUN,
  output logic [ADDR_W-1:0]            S_ADDR,
  output logic [DATA_W-1:0]            S_WDATA,
  output logic [NUM_SLAVES-1:0]        S_WRSTB,
  output logic [NUM_SLAVES-1:0]        S_RDSTB,
  input  logic [NUM_SLAVES*DATA_W-1:0] S_RDATA,
  input  logic [NUM_SLAVES-1:0]        S_ACK
);
  localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [SEL_W-1:0] sel, dec_idx;
  logic dec_hit, wr, err, ack, strobe, timeout;
  logic [7:0] cnt;

  assign strobe = WRSTB | RDSTB;
  assign ack = S_ACK[sel];
  assign timeout = cnt == 8'(TIMEOUT - 1);

  // descending scan so the lowest matching index wins on overlap
  always_comb begin
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((ADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_idx = SEL_W'(i);
        dec_hit = 1'b1;
      end
  end

  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE ? (strobe ? (dec_hit ? REQ : RESP) : IDLE) :
               state == REQ  ? (ack ? RESP : WAIT) :
               state == WAIT ? (ack || timeout ? RESP : WAIT) : IDLE;
  end

  always_comb begin
    READY = state == RESP;
    ERR = READY && err;
    S_WRSTB = state == REQ && wr ? NUM_SLAVES'(1) << sel : '0;
    S_RDSTB = state == REQ && !wr ? NUM_SLAVES'(1) << sel : '0;
  end

  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      S_ADDR <= '0;
      S_WDATA <= '0;
      DATA_O <= '0;
      OVERRUN <= 1'b0;
      wr <= 1'b0;
      sel <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == IDLE && strobe) begin
        S_ADDR <= ADDR;
        S_WDATA <= DATA_I;
        wr <= WRSTB;
        sel <= dec_idx;
        err <= !dec_hit;
        if (!dec_hit && !WRSTB) DATA_O <= ERR_DATA;
      end
      if (state != IDLE && strobe) OVERRUN <= 1'b1;
      cnt <= state == WAIT && !ack ? cnt + 8'd1 : '0;
      if ((state == REQ || state == WAIT) && ack && !wr) DATA_O <= S_RDATA[sel*DATA_W +: DATA_W];
      if (state == WAIT && !ack && timeout) begin
        err <= 1'b1;
        if (!wr) DATA_O <= ERR_DATA;
      end
    end
endmodule

// File: doc/mmio_bus_fabric.md
MMIO_BUS_FABRIC -- requirements
Module: mmio_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4: number of slave ports, legal range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for a slave ACK, legal range 1..255.
REQ-005 SHALL have parameter SLV_BASE, default {0x3000_0000, 0x2000_0000, 0x1000_0000, 0x0000_0000}: per-slave base address, index 0 in the LSBs.
REQ-006 SHALL have parameter SLV_MASK, default 0xF000_0000 for every slave: per-slave decode mask.
REQ-007 SHALL have parameter ERR_DATA, default 0xDEAD_BEEF: read data returned on error.
REQ-008 ACLK  in  1  the single clock; all state updates on its rising edge.
REQ-009 ARESETN  in  1  asynchronous, active-low reset.
REQ-010 ADDR  in  ADDR_W  master address.
REQ-011 DATA_I  in  DATA_W  master write data.
REQ-012 WRSTB  in  1  master write strobe, single-cycle pulse.
REQ-013 RDSTB  in  1  master read strobe, single-cycle pulse.
REQ-014 DATA_O  out  DATA_W  read data returned to the master.
REQ-015 READY  out  1  one-cycle transaction-complete pulse.
REQ-016 ERR  out  1  error qualifier, valid only while READY is high.
REQ-017 OVERRUN  out  1  sticky flag: a master strobe arrived while the fabric was busy.
REQ-018 S_ADDR  out  ADDR_W  registered address, shared by all slaves.
REQ-019 S_WDATA  out  DATA_W  registered write data, shared by all slaves.
REQ-020 S_WRSTB  out  NUM_SLAVES  per-slave write strobe.
REQ-021 S_RDSTB  out  NUM_SLAVES  per-slave read strobe.
REQ-022 S_RDATA  in  NUM_SLAVES*DATA_W  per-slave read data, packed.
REQ-023 S_ACK  in  NUM_SLAVES  per-slave completion pulse.

Function
REQ-024 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-025 Decode: slave i SHALL be selected when (ADDR & SLV_MASK[i]) == SLV_BASE[i]; on overlap the lowest index SHALL win; no match SHALL be treated as unmapped.
REQ-026 In IDLE, a cycle with WRSTB or RDSTB high SHALL latch ADDR, DATA_I, the direction and the decoded index.
- If both strobes are high, the transaction SHALL be a write and the read SHALL be discarded.
REQ-027 IDLE->REQ when the latched address is mapped; IDLE->RESP with error set when it is unmapped.
REQ-028 In REQ, exactly one bit of S_WRSTB or S_RDSTB SHALL be high, for that single cycle only.
- All other strobe bits SHALL be 0 in every state.
REQ-029 S_ACK[sel] SHALL be sampled from the REQ cycle onward.
- ACK in REQ -> RESP.
- No ACK in REQ -> WAIT.
- ACK in WAIT -> RESP.
- ACK from any unselected slave SHALL be ignored.
REQ-030 The timeout counter SHALL clear on entry to REQ and increment in each WAIT cycle without ACK.
- On reaching TIMEOUT: WAIT->RESP with error set, and any later ACK from that slave SHALL be ignored.
REQ-031 RESP SHALL assert READY for exactly one cycle, then return to IDLE.
- Read success: DATA_O = S_RDATA[sel], captured in the ACK cycle.
- Read error: DATA_O = ERR_DATA.
- Writes: DATA_O holds its previous value.
- ERR = 1 on unmapped address or timeout.
REQ-032 Latency from strobe cycle to READY cycle:
- Unmapped: 1.
- Mapped with ACK in REQ: 2.
- Mapped with ACK n cycles after REQ: 2+n.
REQ-033 A strobe seen outside IDLE (including RESP) SHALL be dropped and SHALL set OVERRUN; only reset clears OVERRUN.
REQ-034 S_ADDR and S_WDATA SHALL hold their latched values until the next accepted strobe.

Reset
REQ-035 While ARESETN = 0, all of the following SHALL hold immediately and independently of ACLK:
- FSM in IDLE; timeout counter 0.
- READY, ERR and OVERRUN 0.
- S_WRSTB and S_RDSTB all 0.
- DATA_O, S_ADDR and S_WDATA 0.
REQ-036 Reset mid-transaction SHALL abort it with no READY; a slave ACK arriving after reset release SHALL be ignored.

Verification
REQ-037 Write ADDR=0x1000_0004, DATA_I=0x1234_5678, S_ACK[1] in the REQ cycle -> S_WRSTB=4'b0010 for one cycle, S_WDATA=0x1234_5678, READY at strobe+2, ERR=0.
REQ-038 Read ADDR=0x2000_0010, S_ACK[2] 3 cycles after REQ with S_RDATA[2]=0xCAFE_F00D -> READY at strobe+5, DATA_O=0xCAFE_F00D, ERR=0.
REQ-039 Read ADDR=0x5000_0000 (unmapped) -> no slave strobe, READY at strobe+1, ERR=1, DATA_O=0xDEAD_BEEF.
REQ-040 Read ADDR=0x3000_0000 with no ACK -> READY and ERR=1 at strobe+2+TIMEOUT (=18); an ACK at +20 has no effect.
REQ-041 WRSTB and RDSTB together, followed by a second strobe during WAIT -> write issued, read dropped, second strobe dropped, OVERRUN=1 until reset.
REQ-042 ARESETN low during WAIT, ACK pulsed one cycle after release -> all outputs 0 and no READY.
